// File: rtl/cmd_issue_ctrl_if.sv
// Host/CMD signal bundle for cmd_issue_ctrl: register writes and W1C strobes from the host,
// request/status handshake with the CMD block, and the controller's registered outputs.
interface cmd_issue_ctrl_if;
  logic        arg_wr;
  logic [31:0] arg_wr_data;
  logic        cmd_wr;
  logic [5:0]  cmd_wr_index;
  logic [2:0]  int_clear;
  logic        cmd_busy;
  logic        cmd_busy_en;
  logic        cmd_complete;
  logic        cmd_complete_en;
  logic        timeout_error;
  logic        timeout_error_en;
  logic [31:0] response_status;
  logic [31:0] response_status_en;
  logic        new_cmd;
  logic [31:0] cmd_arg;
  logic [5:0]  cmd_index;
  logic        cmd_inhibit;
  logic [31:0] response_reg;
  logic        cmd_complete_int;
  logic        timeout_int;
  logic        issue_rejected_int;

  modport slave (
    input  arg_wr, arg_wr_data, cmd_wr, cmd_wr_index, int_clear,
    input  cmd_busy, cmd_busy_en, cmd_complete, cmd_complete_en,
    input  timeout_error, timeout_error_en, response_status, response_status_en,
    output new_cmd, cmd_arg, cmd_index, cmd_inhibit, response_reg,
    output cmd_complete_int, timeout_int, issue_rejected_int
  );

  modport master (
    output arg_wr, arg_wr_data, cmd_wr, cmd_wr_index, int_clear,
    output cmd_busy, cmd_busy_en, cmd_complete, cmd_complete_en,
    output timeout_error, timeout_error_en, response_status, response_status_en,
    input  new_cmd, cmd_arg, cmd_index, cmd_inhibit, response_reg,
    input  cmd_complete_int, timeout_int, issue_rejected_int
  );
endinterface

// File: rtl/cmd_issue_ctrl.sv
// Host-side command issue controller: latches Argument/Command writes, requests CMD and tracks
// completion with sticky W1C interrupts. Optional watchdog enabled by CMD_ISSUE_WATCHDOG_EN.
module cmd_issue_ctrl #(
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input logic           CLK_host,
  input logic           reset,
  cmd_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitDone} state_e;

  state_e      state_q, state_d;
  logic        new_cmd_q, new_cmd_d;
  logic        inhibit_q, inhibit_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] response_q, response_d;
  // {issue_rejected, timeout, cmd_complete}
  logic [2:0]  int_q, int_d, int_set;

  logic done_to, done_cc, busy_seen, wd_expire;

  assign done_to   = bus.timeout_error_en && bus.timeout_error;
  assign done_cc   = bus.cmd_complete_en && bus.cmd_complete;
  assign busy_seen = bus.cmd_busy_en && bus.cmd_busy;

`ifdef CMD_ISSUE_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(WATCHDOG_CYCLES) + 1;

  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;

  // Expiry on the edge where the count would reach WATCHDOG_CYCLES.
  assign wd_expire = (state_q != StIdle) && (wd_cnt_q == WdW'(WATCHDOG_CYCLES - 1));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == StIdle) begin
      if (bus.cmd_wr) wd_cnt_d = '0;
    end else begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_host or posedge reset) begin
    if (reset) wd_cnt_q <= '0;
    else       wd_cnt_q <= wd_cnt_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    new_cmd_d   = new_cmd_q;
    inhibit_d   = inhibit_q;
    cmd_arg_d   = cmd_arg_q;
    cmd_index_d = cmd_index_q;
    response_d  = response_q;
    int_set     = 3'b000;

    case (state_q)
      StIdle: begin
        // Same-cycle argument write feeds the command being issued.
        if (bus.arg_wr) cmd_arg_d = bus.arg_wr_data;
        if (bus.cmd_wr) begin
          cmd_index_d = bus.cmd_wr_index;
          state_d     = StReq;
          new_cmd_d   = 1'b1;
          inhibit_d   = 1'b1;
        end
      end
      StReq, StWaitDone: begin
        if (bus.arg_wr || bus.cmd_wr) int_set[2] = 1'b1;
        if (done_to) begin
          int_set[1] = 1'b1;
          state_d    = StIdle;
          new_cmd_d  = 1'b0;
          inhibit_d  = 1'b0;
        end else if (done_cc) begin
          response_d = (bus.response_status & bus.response_status_en) |
                       (response_q & ~bus.response_status_en);
          int_set[0] = 1'b1;
          state_d    = StIdle;
          new_cmd_d  = 1'b0;
          inhibit_d  = 1'b0;
        end else if (wd_expire) begin
          int_set[1] = 1'b1;
          state_d    = StIdle;
          new_cmd_d  = 1'b0;
          inhibit_d  = 1'b0;
        end else if ((state_q == StReq) && busy_seen) begin
          state_d   = StWaitDone;
          new_cmd_d = 1'b0;
        end
      end
      default: begin
        state_d   = StIdle;
        new_cmd_d = 1'b0;
        inhibit_d = 1'b0;
      end
    endcase

    // A set in the same cycle as its clear wins.
    int_d = (int_q & ~bus.int_clear) | int_set;
  end

  always_ff @(posedge CLK_host or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      new_cmd_q   <= 1'b0;
      inhibit_q   <= 1'b0;
      cmd_arg_q   <= '0;
      cmd_index_q <= '0;
      response_q  <= '0;
      int_q       <= '0;
    end else begin
      state_q     <= state_d;
      new_cmd_q   <= new_cmd_d;
      inhibit_q   <= inhibit_d;
      cmd_arg_q   <= cmd_arg_d;
      cmd_index_q <= cmd_index_d;
      response_q  <= response_d;
      int_q       <= int_d;
    end
  end

  assign bus.new_cmd            = new_cmd_q;
  assign bus.cmd_inhibit        = inhibit_q;
  assign bus.cmd_arg            = cmd_arg_q;
  assign bus.cmd_index          = cmd_index_q;
  assign bus.response_reg       = response_q;
  assign bus.cmd_complete_int   = int_q[0];
  assign bus.timeout_int        = int_q[1];
  assign bus.issue_rejected_int = int_q[2];

endmodule

// File: tb/tb_cmd_issue_ctrl.sv
// Directed bench for cmd_issue_ctrl; watchdog vectors run only when CMD_ISSUE_WATCHDOG_EN is set.
module tb_cmd_issue_ctrl;

  logic CLK_host;
  logic reset;
  int   checks;
  int   failures;

  cmd_issue_ctrl_if bus ();

  cmd_issue_ctrl #(
    .WATCHDOG_CYCLES(16)
  ) dut (
    .CLK_host(CLK_host),
    .reset   (reset),
    .bus     (bus.slave)
  );

  initial begin
    CLK_host = 1'b0;
    forever #5 CLK_host = ~CLK_host;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_host);
    #1;
  endtask

  task automatic idle_inputs();
    bus.arg_wr             = 1'b0;
    bus.arg_wr_data        = '0;
    bus.cmd_wr             = 1'b0;
    bus.cmd_wr_index       = '0;
    bus.int_clear          = '0;
    bus.cmd_busy           = 1'b0;
    bus.cmd_busy_en        = 1'b0;
    bus.cmd_complete       = 1'b0;
    bus.cmd_complete_en    = 1'b0;
    bus.timeout_error      = 1'b0;
    bus.timeout_error_en   = 1'b0;
    bus.response_status    = '0;
    bus.response_status_en = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_new_cmd"}, 32'(bus.new_cmd), 32'h0);
    check_eq({tag, "_inhibit"}, 32'(bus.cmd_inhibit), 32'h0);
    check_eq({tag, "_arg"}, bus.cmd_arg, 32'h0);
    check_eq({tag, "_index"}, 32'(bus.cmd_index), 32'h0);
    check_eq({tag, "_resp"}, bus.response_reg, 32'h0);
    check_eq({tag, "_ints"},
             32'({bus.issue_rejected_int, bus.timeout_int, bus.cmd_complete_int}), 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();
    #2;
    check_all_zero("rst");
    tick();
    reset = 1'b0;

    // Argument then command write
    bus.arg_wr = 1'b1; bus.arg_wr_data = 32'h1234_5678;
    tick();
    idle_inputs();
    check_eq("arg_load", bus.cmd_arg, 32'h1234_5678);
    bus.cmd_wr = 1'b1; bus.cmd_wr_index = 6'd17;
    tick();
    idle_inputs();
    check_eq("idx_load", 32'(bus.cmd_index), 32'd17);
    check_eq("new_cmd_rise", 32'(bus.new_cmd), 32'h1);
    check_eq("inhibit_rise", 32'(bus.cmd_inhibit), 32'h1);
    tick();
    check_eq("new_cmd_hold", 32'(bus.new_cmd), 32'h1);
    bus.cmd_busy_en = 1'b1; bus.cmd_busy = 1'b1;
    tick();
    idle_inputs();
    check_eq("new_cmd_drop", 32'(bus.new_cmd), 32'h0);
    check_eq("inhibit_wait", 32'(bus.cmd_inhibit), 32'h1);

    // Writes while in flight are rejected
    bus.cmd_wr = 1'b1; bus.cmd_wr_index = 6'd5;
    bus.arg_wr = 1'b1; bus.arg_wr_data = 32'hCAFE_0000;
    tick();
    idle_inputs();
    check_eq("rej_idx", 32'(bus.cmd_index), 32'd17);
    check_eq("rej_arg", bus.cmd_arg, 32'h1234_5678);
    check_eq("rej_int", 32'(bus.issue_rejected_int), 32'h1);

    // Completion
    bus.cmd_complete_en = 1'b1; bus.cmd_complete = 1'b1;
    bus.response_status = 32'h0000_0900; bus.response_status_en = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    check_eq("cc_resp", bus.response_reg, 32'h0000_0900);
    check_eq("cc_int", 32'(bus.cmd_complete_int), 32'h1);
    check_eq("cc_inhibit", 32'(bus.cmd_inhibit), 32'h0);
    bus.int_clear = 3'b001;
    tick();
    idle_inputs();
    check_eq("clr_cc", 32'(bus.cmd_complete_int), 32'h0);
    check_eq("clr_keeps_rej", 32'(bus.issue_rejected_int), 32'h1);
    bus.int_clear = 3'b100;
    tick();
    idle_inputs();
    check_eq("clr_rej", 32'(bus.issue_rejected_int), 32'h0);

    // Completion in IDLE is ignored
    bus.cmd_complete_en = 1'b1; bus.cmd_complete = 1'b1;
    bus.response_status = 32'h0000_FFFF; bus.response_status_en = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    check_eq("idle_cc_resp", bus.response_reg, 32'h0000_0900);
    check_eq("idle_cc_int", 32'(bus.cmd_complete_int), 32'h0);

    // Same-cycle argument and command write
    bus.arg_wr = 1'b1; bus.arg_wr_data = 32'hDEAD_BEEF;
    bus.cmd_wr = 1'b1; bus.cmd_wr_index = 6'd3;
    tick();
    idle_inputs();
    check_eq("same_arg", bus.cmd_arg, 32'hDEAD_BEEF);
    check_eq("same_idx", 32'(bus.cmd_index), 32'd3);

    // Completion and timeout together in REQ: timeout wins
    bus.cmd_complete_en = 1'b1; bus.cmd_complete = 1'b1;
    bus.timeout_error_en = 1'b1; bus.timeout_error = 1'b1;
    bus.response_status = 32'h0000_AAAA; bus.response_status_en = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    check_eq("both_to", 32'(bus.timeout_int), 32'h1);
    check_eq("both_cc", 32'(bus.cmd_complete_int), 32'h0);
    check_eq("both_resp", bus.response_reg, 32'h0000_0900);
    check_eq("both_inhibit", 32'(bus.cmd_inhibit), 32'h0);
    check_eq("both_new_cmd", 32'(bus.new_cmd), 32'h0);

    // Masked capture, completion straight from REQ, set beats clear
    bus.cmd_wr = 1'b1; bus.cmd_wr_index = 6'd8;
    tick();
    idle_inputs();
    bus.cmd_complete_en = 1'b1; bus.cmd_complete = 1'b1;
    bus.response_status = 32'h0000_00FF; bus.response_status_en = 32'h0000_000F;
    bus.int_clear = 3'b001;
    tick();
    idle_inputs();
    check_eq("mask_resp", bus.response_reg, 32'h0000_090F);
    check_eq("set_beats_clr", 32'(bus.cmd_complete_int), 32'h1);
    check_eq("req_cc_inhibit", 32'(bus.cmd_inhibit), 32'h0);

    // Asynchronous reset during REQ
    bus.cmd_wr = 1'b1; bus.cmd_wr_index = 6'd9;
    tick();
    idle_inputs();
    check_eq("pre_rst_new_cmd", 32'(bus.new_cmd), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    reset = 1'b0;
    bus.cmd_complete_en = 1'b1; bus.cmd_complete = 1'b1;
    bus.response_status = 32'h1111_1111; bus.response_status_en = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    check_eq("post_rst_cc", 32'(bus.cmd_complete_int), 32'h0);
    check_eq("post_rst_resp", bus.response_reg, 32'h0);

`ifdef CMD_ISSUE_WATCHDOG_EN
    bus.cmd_wr = 1'b1; bus.cmd_wr_index = 6'd2;
    tick();
    idle_inputs();
    check_eq("wd_new_cmd", 32'(bus.new_cmd), 32'h1);
    repeat (15) tick();
    check_eq("wd_still_busy", 32'(bus.cmd_inhibit), 32'h1);
    check_eq("wd_not_yet", 32'(bus.timeout_int), 32'h0);
    tick();
    check_eq("wd_to", 32'(bus.timeout_int), 32'h1);
    check_eq("wd_inhibit", 32'(bus.cmd_inhibit), 32'h0);
    check_eq("wd_new_cmd_low", 32'(bus.new_cmd), 32'h0);
    bus.cmd_complete_en = 1'b1; bus.cmd_complete = 1'b1;
    bus.response_status = 32'h2222_2222; bus.response_status_en = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    check_eq("wd_late_cc", 32'(bus.cmd_complete_int), 32'h0);
    check_eq("wd_late_resp", bus.response_reg, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
